// File: rtl/rf_pkg.sv
// Shared register-file constants and types, reused by the ID and WB stages.
package rf_pkg;

  localparam int DATA_W       = 32;
  localparam int NUM_REGS     = 32;
  localparam int REG_ADDR_W   = $clog2(NUM_REGS);
  localparam int CNT_W        = 2;   // up to three writers in flight: EX, MEM, WB
  localparam int ZERO_REG_IDX = 0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     word_t;
  typedef logic [CNT_W-1:0]      cnt_t;

endpackage

// File: rtl/sb_counter.sv
// One scoreboard entry: saturating pending-write counter with overflow/underflow strobes.
module sb_counter
  import rf_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output cnt_t cnt,
  output logic ovf,
  output logic udf
);

  // Simultaneous inc and dec cancel, so neither saturation case applies then.
  assign ovf = inc & ~dec & (cnt == '1);
  assign udf = dec & ~inc & (cnt == '0);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (inc && !dec && !ovf) begin
      cnt <= cnt + cnt_t'(1);
    end else if (dec && !inc && !udf) begin
      cnt <= cnt - cnt_t'(1);
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// 32x32 register file with per-register pending-write scoreboard and RAW hazard output.
// Optional write-through bypass from the WB port is enabled by defining RF_BYPASS_EN.
module reg_file_sb
  import rf_pkg::*;
#(
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  WB_en,
  input  logic [REG_ADDR_W-1:0] WB_Dest,
  input  logic [DATA_W-1:0]     WB_Value,
  input  logic [REG_ADDR_W-1:0] src1,
  input  logic [REG_ADDR_W-1:0] src2,
  input  logic                  use_src2,
  input  logic                  issue,
  input  logic                  issue_wb_en,
  input  logic [REG_ADDR_W-1:0] issue_dest,
  output logic [DATA_W-1:0]     reg1,
  output logic [DATA_W-1:0]     reg2,
  output logic                  hazard,
  output logic                  sb_err
);

  word_t               regs [NUM_REGS];
  cnt_t                cnt  [NUM_REGS];
  logic [NUM_REGS-1:0] inc, dec, ovf, udf, busy;
  logic                wb_live;

  function automatic logic is_zero(input reg_addr_t a);
    return ZERO_REG && (a == reg_addr_t'(ZERO_REG_IDX));
  endfunction

  assign wb_live = WB_en & ~is_zero(WB_Dest);

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_sb
    localparam reg_addr_t R = reg_addr_t'(r);

    assign inc[r] = issue & issue_wb_en & (issue_dest == R) & ~is_zero(R);
    assign dec[r] = wb_live & (WB_Dest == R);

    sb_counter u_cnt (
      .clk (clk),
      .rst (rst),
      .inc (inc[r]),
      .dec (dec[r]),
      .cnt (cnt[r]),
      .ovf (ovf[r]),
      .udf (udf[r])
    );

`ifdef RF_BYPASS_EN
    // The last pending write landing this cycle is forwarded, so it no longer blocks.
    assign busy[r] = (cnt[r] > cnt_t'(1)) | ((cnt[r] == cnt_t'(1)) & ~dec[r]);
`else
    assign busy[r] = (cnt[r] != '0);
`endif
  end

  assign hazard = busy[src1] | (use_src2 & busy[src2]);

  // NOTE: the array is architecturally visible after reset, so every entry is cleared here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wb_live) begin
      regs[WB_Dest] <= WB_Value;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_err <= 1'b0;
    end else if ((|ovf) || (|udf)) begin
      sb_err <= 1'b1;
    end
  end

  // NOTE: each combinational output gets a default first so no latch is inferred.
  always_comb begin
    reg1 = regs[src1];
`ifdef RF_BYPASS_EN
    if (wb_live && (WB_Dest == src1)) reg1 = WB_Value;
`endif
    if (is_zero(src1)) reg1 = '0;
  end

  always_comb begin
    reg2 = regs[src2];
`ifdef RF_BYPASS_EN
    if (wb_live && (WB_Dest == src2)) reg2 = WB_Value;
`endif
    if (is_zero(src2)) reg2 = '0;
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed self-checking bench for reg_file_sb; expectations adapt to RF_BYPASS_EN.
module tb_reg_file_sb;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        WB_en;
  logic [4:0]  WB_Dest;
  logic [31:0] WB_Value;
  logic [4:0]  src1, src2;
  logic        use_src2, issue, issue_wb_en;
  logic [4:0]  issue_dest;
  logic [31:0] reg1, reg2;
  logic        hazard, sb_err;

  int total  = 0;
  int passed = 0;

  reg_file_sb dut (
    .clk         (clk),
    .rst         (rst),
    .WB_en       (WB_en),
    .WB_Dest     (WB_Dest),
    .WB_Value    (WB_Value),
    .src1        (src1),
    .src2        (src2),
    .use_src2    (use_src2),
    .issue       (issue),
    .issue_wb_en (issue_wb_en),
    .issue_dest  (issue_dest),
    .reg1        (reg1),
    .reg2        (reg2),
    .hazard      (hazard),
    .sb_err      (sb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        wb_en;
    logic [4:0]  wb_dest;
    logic [31:0] wb_val;
    logic [4:0]  s1, s2;
    logic        use2, iss, iss_wb;
    logic [4:0]  iss_dest;
    logic [31:0] e1, e2;
    logic        eh, ee;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    else passed++;
  endtask

  task automatic idle();
    WB_en = 0; WB_Dest = 0; WB_Value = 0;
    src1 = 0; src2 = 0; use_src2 = 0;
    issue = 0; issue_wb_en = 0; issue_dest = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_issue(input logic [4:0] d);
    issue = 1; issue_wb_en = 1; issue_dest = d;
  endtask

  task automatic do_wb(input logic [4:0] d, input logic [31:0] v);
    WB_en = 1; WB_Dest = d; WB_Value = v;
  endtask

  vec_t vecs [9];

  initial begin
    vecs[0] = '{"wr5_rd1",   1, 5,  32'hDEADBEEF, 1,  0,  0, 0, 0, 0,  32'h0,        32'h0,        0, 0};
    vecs[1] = '{"rd5_both",  0, 0,  32'h0,        5,  5,  1, 0, 0, 0,  32'hDEADBEEF, 32'hDEADBEEF, 0, 1};
    vecs[2] = '{"wr0_rd0",   1, 0,  32'h00001234, 0,  5,  0, 0, 0, 0,  32'h0,        32'hDEADBEEF, 0, 1};
    vecs[3] = '{"iss0",      0, 0,  32'h0,        0,  0,  0, 1, 1, 0,  32'h0,        32'h0,        0, 1};
    vecs[4] = '{"rd0_nohaz", 0, 0,  32'h0,        0,  0,  1, 0, 0, 0,  32'h0,        32'h0,        0, 1};
    vecs[5] = '{"wr10",      1, 10, 32'hA5A50001, 11, 12, 0, 0, 0, 0,  32'h0,        32'h0,        0, 1};
    vecs[6] = '{"rd10_5",    0, 0,  32'h0,        10, 5,  0, 0, 0, 0,  32'hA5A50001, 32'hDEADBEEF, 0, 1};
    vecs[7] = '{"iss_nowb",  0, 0,  32'h0,        10, 11, 1, 1, 0, 11, 32'hA5A50001, 32'h0,        0, 1};
    vecs[8] = '{"rd11",      0, 0,  32'h0,        11, 11, 1, 0, 0, 0,  32'h0,        32'h0,        0, 1};

    // Reset state
    idle();
    rst = 0;
    src1 = 5; src2 = 7;
    #3;
    check("rst_reg1",   reg1,   32'h0);
    check("rst_reg2",   reg2,   32'h0);
    check("rst_hazard", {31'b0, hazard}, 32'h0);
    check("rst_sb_err", {31'b0, sb_err}, 32'h0);
    @(negedge clk);
    rst = 1;
    tick();

    // Table: writes, reads, R0 behaviour, untracked writeback (underflow)
    for (int i = 0; i < 9; i++) begin
      WB_en = vecs[i].wb_en; WB_Dest = vecs[i].wb_dest; WB_Value = vecs[i].wb_val;
      src1 = vecs[i].s1; src2 = vecs[i].s2; use_src2 = vecs[i].use2;
      issue = vecs[i].iss; issue_wb_en = vecs[i].iss_wb; issue_dest = vecs[i].iss_dest;
      #1;
      check({vecs[i].name, "_reg1"}, reg1, vecs[i].e1);
      check({vecs[i].name, "_reg2"}, reg2, vecs[i].e2);
      check({vecs[i].name, "_haz"},  {31'b0, hazard}, {31'b0, vecs[i].eh});
      check({vecs[i].name, "_err"},  {31'b0, sb_err}, {31'b0, vecs[i].ee});
      tick();
    end

    // Mid-operation reset clears data and the sticky flag
    idle();
    src1 = 5;
    rst = 0;
    #1;
    check("rst2_sb_err", {31'b0, sb_err}, 32'h0);
    check("rst2_reg1",   reg1, 32'h0);
    rst = 1;
    tick();

    // RAW stall on r3
    idle(); do_issue(3); tick();
    idle(); src1 = 3; #1;
    check("raw_c1_haz", {31'b0, hazard}, 32'h1);
    src1 = 0; src2 = 3; use_src2 = 0; #1;
    check("raw_src2_unused", {31'b0, hazard}, 32'h0);
    use_src2 = 1; #1;
    check("raw_src2_used", {31'b0, hazard}, 32'h1);
    tick();
    idle(); src1 = 3; #1;
    check("raw_c2_haz", {31'b0, hazard}, 32'h1);
    tick();
    do_wb(3, 32'h0BADF00D); #1;
    check("raw_wb_haz",  {31'b0, hazard}, BYP ? 32'h0 : 32'h1);
    check("raw_wb_reg1", reg1, BYP ? 32'h0BADF00D : 32'h0);
    tick();
    idle(); src1 = 3; #1;
    check("raw_after_haz",  {31'b0, hazard}, 32'h0);
    check("raw_after_reg1", reg1, 32'h0BADF00D);

    // Three back-to-back writers to r7
    tick();
    for (int i = 0; i < 3; i++) begin
      idle(); src1 = 7; do_issue(7); #1;
      check($sformatf("b2b_iss%0d_haz", i), {31'b0, hazard}, (i == 0) ? 32'h0 : 32'h1);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      idle(); src1 = 7; do_wb(7, 32'h71 + i); #1;
      check($sformatf("b2b_wb%0d_haz", i), {31'b0, hazard}, (i == 2 && BYP) ? 32'h0 : 32'h1);
      tick();
    end
    idle(); src1 = 7; #1;
    check("b2b_done_haz",  {31'b0, hazard}, 32'h0);
    check("b2b_done_reg1", reg1, 32'h73);
    check("b2b_done_err",  {31'b0, sb_err}, 32'h0);

    // Simultaneous issue and writeback on r9 at cnt=1
    tick();
    idle(); do_issue(9); tick();
    idle(); src1 = 9; do_issue(9); do_wb(9, 32'h99); #1;
    check("sim_same_haz", {31'b0, hazard}, BYP ? 32'h0 : 32'h1);
    tick();
    idle(); src1 = 9; #1;
    check("sim_held_haz", {31'b0, hazard}, 32'h1);
    src1 = 0; src2 = 9; use_src2 = 0; #1;
    check("sim_src2_off", {31'b0, hazard}, 32'h0);
    use_src2 = 1; #1;
    check("sim_src2_on",  {31'b0, hazard}, 32'h1);
    idle(); do_wb(9, 32'h9A); tick();
    idle(); src1 = 9; #1;
    check("sim_drain_haz",  {31'b0, hazard}, 32'h0);
    check("sim_drain_reg1", reg1, 32'h9A);
    check("sim_drain_err",  {31'b0, sb_err}, 32'h0);

    // Overflow on r4, then underflow on untracked r6
    tick();
    for (int i = 0; i < 3; i++) begin
      idle(); do_issue(4); tick();
    end
    idle(); src1 = 4; #1;
    check("ovf_pre_err", {31'b0, sb_err}, 32'h0);
    check("ovf_pre_haz", {31'b0, hazard}, 32'h1);
    do_issue(4); tick();
    idle(); src1 = 4; #1;
    check("ovf_err", {31'b0, sb_err}, 32'h1);
    check("ovf_haz", {31'b0, hazard}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      idle(); do_wb(4, 32'h40 + i); tick();
      idle(); src1 = 4; #1;
      check($sformatf("ovf_drain%0d_haz", i), {31'b0, hazard}, (i == 2) ? 32'h0 : 32'h1);
    end
    check("ovf_sticky", {31'b0, sb_err}, 32'h1);
    idle(); do_wb(6, 32'h66); tick();
    idle(); src1 = 6; #1;
    check("udf_reg1", reg1, 32'h66);
    check("udf_haz",  {31'b0, hazard}, 32'h0);
    check("udf_err",  {31'b0, sb_err}, 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
